// File: rtl/register_file_mp_pkg.sv
// Core-wide types and sizing shared by the register file and its scoreboard.
// RV32E builds shrink the default architectural register count to 16.
package register_file_mp_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [XLEN-1:0] word_t;

`ifdef FEATURE_RV32E
    localparam int DEFAULT_NUM_REGS = 16;
`else
    localparam int DEFAULT_NUM_REGS = 32;
`endif

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Busy-bit scoreboard: one pending flag per architectural register.
// Indices arrive already folded into range, so entry 0 is the only sink to mask.
module reg_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int NUM_REGS        = DEFAULT_NUM_REGS,
    parameter int NUM_WRITE_PORTS = 1,
    parameter int IDX_W           = $clog2(NUM_REGS)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [NUM_WRITE_PORTS-1:0]            wr_en_i,
    input  logic [NUM_WRITE_PORTS-1:0][IDX_W-1:0] wr_idx_i,
    input  logic                                  issue_en_i,
    input  logic [IDX_W-1:0]                      issue_idx_i,
    input  logic                                  flush_i,
    output logic [NUM_REGS-1:0]                   busy_o
);

    logic [NUM_REGS-1:0] busy_r = '0;
    logic [NUM_REGS-1:0] busy_next_s;

    // Next pending set: flush/clear first, then the issue set so it wins.
    always_comb begin
        busy_next_s = flush_i ? '0 : busy_r;
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            busy_next_s[wr_idx_i[k]] = wr_en_i[k] ? 1'b0 : busy_next_s[wr_idx_i[k]];
        end
        if (issue_en_i) begin
            busy_next_s[issue_idx_i] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        busy_next_s[0] = 1'b0;
    end

    // Pending-bit state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign busy_o = busy_r;

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported integer register file with write arbitration, optional
// write-to-read bypass and a busy-bit scoreboard for in-flight destinations.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int NUM_REGS        = DEFAULT_NUM_REGS,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 1,
    parameter int FORWARD         = 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [NUM_READ_PORTS-1:0][REG_IDX_W-1:0]  rd_addr_i,
    output word_t [NUM_READ_PORTS-1:0]                rd_data_o,
    output logic [NUM_READ_PORTS-1:0]                 rd_ready_o,
    input  logic [NUM_WRITE_PORTS-1:0]                wr_en_i,
    input  logic [NUM_WRITE_PORTS-1:0][REG_IDX_W-1:0] wr_addr_i,
    input  word_t [NUM_WRITE_PORTS-1:0]               wr_data_i,
    input  logic                                      issue_en_i,
    input  logic [REG_IDX_W-1:0]                      issue_addr_i,
    input  logic                                      flush_i,
    output logic [NUM_REGS-1:0]                       busy_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // Out-of-range indices alias x0 so they can never touch real state.
    function automatic logic [IDX_W-1:0] map_idx(input logic [REG_IDX_W-1:0] addr);
        logic [IDX_W-1:0] idx;
        if (32'(addr) < 32'(NUM_REGS)) begin
            idx = addr[IDX_W-1:0];
        end else begin
            idx = '0;
        end
        return idx;
    endfunction

    word_t [NUM_REGS-1:0]                  regs_r = '0;
    word_t [NUM_REGS-1:0]                  regs_next_s;
    logic [NUM_READ_PORTS-1:0][IDX_W-1:0]  rd_idx_s;
    logic [NUM_WRITE_PORTS-1:0][IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0]                      issue_idx_s;
    logic [NUM_READ_PORTS-1:0]             fwd_hit_s;
    logic                                  fwd_match_s;

    // Fold every incoming register index into the implemented range.
    always_comb begin
        rd_idx_s    = '0;
        wr_idx_s    = '0;
        issue_idx_s = map_idx(issue_addr_i);
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_idx_s[p] = map_idx(rd_addr_i[p]);
        end
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            wr_idx_s[k] = map_idx(wr_addr_i[k]);
        end
    end

    // Write arbitration: ascending port order lets the highest port win.
    always_comb begin
        regs_next_s = regs_r;
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            regs_next_s[wr_idx_s[k]] = (wr_en_i[k] && (wr_idx_s[k] != '0)) ?
                                       wr_data_i[k] : regs_next_s[wr_idx_s[k]];
        end
        regs_next_s[0] = '0;
    end

    // Architectural storage with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            regs_r <= '0;
        end else begin
            regs_r <= regs_next_s;
        end
    end

    // Combinational read with optional same-cycle bypass from write-back.
    always_comb begin
        rd_data_o   = '0;
        rd_ready_o  = '0;
        fwd_hit_s   = '0;
        fwd_match_s = 1'b0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_data_o[p] = regs_r[rd_idx_s[p]];
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                fwd_match_s  = (FORWARD != 0) && wr_en_i[k] &&
                               (wr_idx_s[k] == rd_idx_s[p]) && (rd_idx_s[p] != '0);
                rd_data_o[p] = fwd_match_s ? wr_data_i[k] : rd_data_o[p];
                fwd_hit_s[p] = fwd_hit_s[p] | fwd_match_s;
            end
            rd_ready_o[p] = !(busy_o[rd_idx_s[p]] && !fwd_hit_s[p]);
        end
    end

    reg_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
        .IDX_W           (IDX_W)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .wr_en_i     (wr_en_i),
        .wr_idx_i    (wr_idx_s),
        .issue_en_i  (issue_en_i),
        .issue_idx_i (issue_idx_s),
        .flush_i     (flush_i),
        .busy_o      (busy_o)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: two register-file builds (32 regs with bypass, 16 regs
// without) driven by identical stimulus, each checked against hand values.
module tb_register_file_mp;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [1:0][4:0]  rd_addr = '0;
    logic [1:0][31:0] rd_data_a;
    logic [1:0][31:0] rd_data_b;
    logic [1:0]       ready_a;
    logic [1:0]       ready_b;
    logic [1:0]       wr_en = '0;
    logic [1:0][4:0]  wr_addr = '0;
    logic [1:0][31:0] wr_data = '0;
    logic             issue_en = 1'b0;
    logic [4:0]       issue_addr = '0;
    logic             flush = 1'b0;
    logic [31:0]      busy_a;
    logic [15:0]      busy_b;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    register_file_mp #(
        .NUM_REGS(32), .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(2), .FORWARD(1)
    ) dut_a (
        .clk_i(clk), .reset_i(reset_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
        .rd_ready_o(ready_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .flush_i(flush), .busy_o(busy_a)
    );

    register_file_mp #(
        .NUM_REGS(16), .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(2), .FORWARD(0)
    ) dut_b (
        .clk_i(clk), .reset_i(reset_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .rd_ready_o(ready_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .flush_i(flush), .busy_o(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = '0;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        rd_addr[0] = 5'd5;
        #1;
        check_eq("rst_busy_a", busy_a, 32'h0);
        check_eq("rst_busy_b", {16'h0, busy_b}, 32'h0);
        check_eq("rst_data_a", rd_data_a[0], 32'h0);
        check_eq("rst_ready_a", {30'h0, ready_a}, 32'h3);

        // Write x5, read back on port 1 next cycle
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        tick();
        idle_inputs();
        rd_addr[1] = 5'd5;
        #1;
        check_eq("x5_data_a", rd_data_a[1], 32'hDEADBEEF);
        check_eq("x5_data_b", rd_data_b[1], 32'hDEADBEEF);
        check_eq("x5_ready_a", {31'h0, ready_a[1]}, 32'h1);

        // Same-cycle bypass vs stored value
        wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h12345678;
        rd_addr[0] = 5'd7;
        #1;
        check_eq("fwd_x7_a", rd_data_a[0], 32'h12345678);
        check_eq("nofwd_x7_b", rd_data_b[0], 32'h0);
        tick();
        idle_inputs();
        #1;
        check_eq("x7_after_b", rd_data_b[0], 32'h12345678);

        // Two ports to x3: highest port wins
        wr_en = 2'b11; wr_addr[0] = 5'd3; wr_addr[1] = 5'd3;
        wr_data[0] = 32'h1111; wr_data[1] = 32'h2222;
        tick();
        idle_inputs();
        rd_addr[0] = 5'd3;
        #1;
        check_eq("x3_arb_a", rd_data_a[0], 32'h2222);
        check_eq("x3_arb_b", rd_data_b[0], 32'h2222);

        // x0 ignores writes and never forwards
        wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
        rd_addr[0] = 5'd0;
        #1;
        check_eq("x0_fwd_a", rd_data_a[0], 32'h0);
        tick();
        idle_inputs();
        #1;
        check_eq("x0_store_a", rd_data_a[0], 32'h0);

        // Issue x9 marks it pending
        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        idle_inputs();
        rd_addr[0] = 5'd9;
        #1;
        check_eq("x9_busy_a", busy_a, 32'h200);
        check_eq("x9_busy_b", {16'h0, busy_b}, 32'h200);
        check_eq("x9_ready_a", {31'h0, ready_a[0]}, 32'h0);
        check_eq("x9_ready_b", {31'h0, ready_b[0]}, 32'h0);

        // Write-back in flight: bypass makes it ready only with forwarding
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h99;
        #1;
        check_eq("x9_wb_ready_a", {31'h0, ready_a[0]}, 32'h1);
        check_eq("x9_wb_ready_b", {31'h0, ready_b[0]}, 32'h0);
        tick();
        idle_inputs();
        #1;
        check_eq("x9_clr_busy_a", busy_a, 32'h0);
        check_eq("x9_clr_busy_b", {16'h0, busy_b}, 32'h0);
        check_eq("x9_clr_ready_b", {31'h0, ready_b[0]}, 32'h1);
        check_eq("x9_data_b", rd_data_b[0], 32'h99);

        // Same-cycle issue and write-back: issue wins
        issue_en = 1'b1; issue_addr = 5'd9;
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h77;
        tick();
        idle_inputs();
        #1;
        check_eq("x9_issue_wins_a", busy_a, 32'h200);
        check_eq("x9_issue_wins_b", {16'h0, busy_b}, 32'h200);

        // Flush clears all, same-cycle issue x4 and write x6 still land
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd4;
        wr_en = 2'b01; wr_addr[0] = 5'd6; wr_data[0] = 32'h66;
        tick();
        idle_inputs();
        rd_addr[1] = 5'd6;
        #1;
        check_eq("flush_busy_a", busy_a, 32'h10);
        check_eq("flush_busy_b", {16'h0, busy_b}, 32'h10);
        check_eq("flush_wr_a", rd_data_a[1], 32'h66);

        // x20 is real on 32 regs, aliases x0 on 16 regs
        wr_en = 2'b01; wr_addr[0] = 5'd20; wr_data[0] = 32'hAA;
        issue_en = 1'b1; issue_addr = 5'd20;
        tick();
        idle_inputs();
        rd_addr[0] = 5'd20;
        #1;
        check_eq("x20_data_a", rd_data_a[0], 32'hAA);
        check_eq("x20_data_b", rd_data_b[0], 32'h0);
        check_eq("x20_busy_a", busy_a, 32'h00100010);
        check_eq("x20_busy_b", {16'h0, busy_b}, 32'h10);

        // Both ports write x12 same cycle: bypass picks the higher port
        wr_en = 2'b11; wr_addr[0] = 5'd12; wr_addr[1] = 5'd12;
        wr_data[0] = 32'hA; wr_data[1] = 32'hB;
        rd_addr[1] = 5'd12;
        #1;
        check_eq("x12_fwd_a", rd_data_a[1], 32'hB);
        check_eq("x12_nofwd_b", rd_data_b[1], 32'h0);
        tick();
        idle_inputs();

        // Reset overrides a write and an issue in the same cycle
        reset_n = 1'b0;
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'h55;
        issue_en = 1'b1; issue_addr = 5'd8;
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd7;
        #1;
        check_eq("rst_pre_view_b", rd_data_b[0], 32'hDEADBEEF);
        tick();
        reset_n = 1'b1;
        idle_inputs();
        #1;
        check_eq("post_rst_x5_a", rd_data_a[0], 32'h0);
        check_eq("post_rst_x7_b", rd_data_b[1], 32'h0);
        check_eq("post_rst_busy_a", busy_a, 32'h0);
        check_eq("post_rst_busy_b", {16'h0, busy_b}, 32'h0);
        check_eq("post_rst_ready_a", {30'h0, ready_a}, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers; legal values 32 (RV32I) and 16 (RV32E).
REQ-002 SHALL have parameter NUM_READ_PORTS, default 2, number of independent read ports, range 1..4.
REQ-003 SHALL have parameter NUM_WRITE_PORTS, default 1, number of independent write ports, range 1..2.
REQ-004 SHALL have parameter FORWARD, default 1, which enables same-cycle write-to-read bypass when 1.
REQ-005 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_i  input  1  synchronous, active-low reset.
REQ-007 SHALL have port rd_addr_i  input  NUM_READ_PORTS x 5  read register index per port.
REQ-008 SHALL have port rd_data_o  output  NUM_READ_PORTS x word_t  read data per port.
REQ-009 SHALL have port rd_ready_o  output  NUM_READ_PORTS x 1  high when the read value is final (not pending).
REQ-010 SHALL have port wr_en_i  input  NUM_WRITE_PORTS x 1  write-back strobe per port.
REQ-011 SHALL have port wr_addr_i  input  NUM_WRITE_PORTS x 5  write-back destination per port.
REQ-012 SHALL have port wr_data_i  input  NUM_WRITE_PORTS x word_t  write-back data per port.
REQ-013 SHALL have port issue_en_i  input  1  marks issue_addr_i as pending (scoreboard set).
REQ-014 SHALL have port issue_addr_i  input  5  destination register of the issuing instruction.
REQ-015 SHALL have port flush_i  input  1  clears all pending marks (pipeline flush).
REQ-016 SHALL have port busy_o  output  NUM_REGS  per-register pending bits, registered.

Function
REQ-017 SHALL store NUM_REGS words; register 0 SHALL read 0, never be pending, and ignore writes and issues.
REQ-018 SHALL treat any index >= NUM_REGS as register 0 for reads, writes and issues.
REQ-019 SHALL update storage on the clock edge when wr_en_i[k] is high; write latency is 1 cycle.
REQ-020 SHALL resolve equal wr_addr_i on multiple enabled write ports in favour of the highest port index.
REQ-021 SHALL provide combinational reads: rd_data_o reflects storage with zero-cycle latency.
REQ-022 SHALL, when FORWARD=1, return the enabled same-cycle wr_data_i (highest-index port) for a matching nonzero rd_addr_i; when FORWARD=0, return stored data only.
REQ-023 SHALL set busy for issue_addr_i on the edge where issue_en_i is high.
REQ-024 SHALL clear busy for wr_addr_i[k] on the edge where wr_en_i[k] is high.
REQ-025 SHALL let the issue set win over a write-back clear to the same register in the same cycle.
REQ-026 SHALL clear all busy bits on flush_i; a same-cycle issue_en_i SHALL still set its bit, and same-cycle writes SHALL still update storage.
REQ-027 SHALL drive rd_ready_o[p] low iff the addressed register is busy and (FORWARD=0 or no same-cycle write matches it).

Reset
REQ-028 SHALL, on a clock edge with reset_i low, clear all registers to 0 and all busy bits to 0, overriding writes, issues and flush.
REQ-029 SHALL, during reset, present rd_data_o as the combinational view of the current (possibly pre-reset) contents and rd_ready_o per REQ-027; after the first reset edge, rd_data_o = 0 and rd_ready_o = all 1 until the first write.
REQ-030 SHALL initialise storage and busy bits to 0 at time zero for simulation.

Structure
REQ-031 SHALL take word_t, XLEN and the register-index width from the shared core package; the RV32E default SHALL follow the existing FEATURE_RV32E define.
REQ-032 SHALL factor the busy-bit scoreboard into one sub-module named reg_scoreboard; storage, write arbitration and forwarding stay in register_file_mp.

Verification
REQ-033 SHALL cover: write x5=0xDEADBEEF, read x5 on port 1 the next cycle -> 0xDEADBEEF, rd_ready_o=1.
REQ-034 SHALL cover: FORWARD=1, write x7=0x12345678 and read x7 in the same cycle -> 0x12345678; with FORWARD=0 -> old value 0.
REQ-035 SHALL cover: two write ports both target x3 (0x1111, 0x2222) -> x3 reads 0x2222; write x0=0xFFFFFFFF -> x0 reads 0.
REQ-036 SHALL cover: issue x9, then read x9 -> rd_ready_o=0; write-back x9 -> busy_o[9]=0 next cycle; same-cycle issue and write-back of x9 -> busy_o[9]=1.
REQ-037 SHALL cover: NUM_REGS=16, write x20=0xAA -> ignored, x20 reads 0, busy_o unchanged.
REQ-038 SHALL cover: registers and busy bits populated, reset_i low one cycle with wr_en_i high -> all reads 0, busy_o=0.
